// File: rtl/i2c_target_rx.sv
// Write-only I2C target: receives an address byte plus two data bytes and
// commits them as one 7-bit register address / 9-bit data write strobe.
module i2c_target_rx #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;
  logic [3:0]             bit_cnt;
  logic [7:0]             shreg;
  logic [6:0]             shadow_addr;
  logic [8:0]             shadow_data;

  // Synchronizers reset to 1 so an idle bus produces no spurious edges.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  // START/STOP are checked first so they win over any coincident SCL edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      shadow_addr <= '0;
      shadow_data <= '0;
      sda_oe      <= 1'b0;
      wr_valid    <= 1'b0;
      busy        <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (stop_det) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        sda_oe      <= 1'b0;
        busy        <= 1'b0;
        shadow_addr <= '0;
        shadow_data <= '0;
      end else if (start_det) begin
        state       <= ADDR;
        bit_cnt     <= '0;
        sda_oe      <= 1'b0;
        shadow_addr <= '0;
        shadow_data <= '0;
      end else begin
        case (state)
          ADDR, BYTE1, BYTE2: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == ADDR) begin
                if (shreg[7:1] == DEV_ADDR && !shreg[0]) begin
                  state  <= ACK_A;
                  sda_oe <= 1'b1;
                  busy   <= 1'b1;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else if (state == BYTE1) begin
                shadow_addr    <= shreg[7:1];
                shadow_data[8] <= shreg[0];
                state          <= ACK_1;
                sda_oe         <= 1'b1;
              end else begin
                shadow_data[7:0] <= shreg;
                state            <= ACK_2;
                sda_oe           <= 1'b1;
              end
            end
          end
          ACK_A: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= BYTE1;
            end
          end
          ACK_1: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= BYTE2;
            end
          end
          ACK_2: begin
            if (scl_fall) begin
              sda_oe   <= 1'b0;
              state    <= WAIT_STOP;
              wr_addr  <= shadow_addr;
              wr_data  <= shadow_data;
              wr_valid <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: a bit-banged I2C master drives the bus while a
// monitor pops expected writes from a scoreboard queue on every wr_valid.
module tb_i2c_target_rx;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;

  int checks      = 0;
  int fails       = 0;
  int quarter     = 10;
  int ack_count   = 0;
  int busy_cycles = 0;
  int valid_count = 0;
  logic [15:0] exp_q[$];

  always #10 clk_in = ~clk_in;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_rx #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .scl_in  (scl_m),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  task automatic check_output(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic expect_write(input logic [6:0] addr, input logic [8:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Samples on the falling clock edge, away from the DUT's active edge.
  task automatic monitor();
    logic        prev_oe = 1'b0;
    logic [15:0] exp;
    forever begin
      @(negedge clk_in);
      if (sda_oe && !prev_oe) ack_count++;
      prev_oe = sda_oe;
      if (busy) busy_cycles++;
      if (wr_valid) begin
        valid_count++;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL wr_valid_unexpected: got addr=%0h data=%0h, required no strobe",
                   wr_addr, wr_data);
        end else begin
          exp = exp_q.pop_front();
          if ({wr_addr, wr_data} !== exp) begin
            fails++;
            $display("[TB] FAIL write_payload: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     wr_addr, wr_data, exp[15:9], exp[8:0]);
          end
        end
      end
    end
  endtask

  task automatic wait_q();
    repeat (quarter) @(posedge clk_in);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
    end
  endtask

  // One byte plus the ninth (ACK) clock; the ACK is sampled mid-high.
  task automatic apply_stimulus(input logic [7:0] b, input logic exp_ack, input string name);
    logic ack_bit;
    send_bits(b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack_bit = ~sda_bus;
    check_output({name, "_ack"}, 32'(ack_bit), 32'(exp_ack));
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  initial begin
    int v0, a0, b0;
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    fork monitor(); join_none

    repeat (5) @(posedge clk_in);
    #1;
    check_output("reset_sda_oe",   32'(sda_oe),   0);
    check_output("reset_wr_valid", 32'(wr_valid), 0);
    check_output("reset_busy",     32'(busy),     0);
    check_output("reset_wr_addr",  32'(wr_addr),  0);
    check_output("reset_wr_data",  32'(wr_data),  0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;

    // ~62.5 kHz SCL: 0x34, 0x1E, 0x00.
    quarter = 200;
    v0 = valid_count; a0 = ack_count;
    expect_write(7'h0F, 9'h000);
    i2c_start();
    apply_stimulus(8'h34, 1'b1, "t1_addr");
    apply_stimulus(8'h1E, 1'b1, "t1_b1");
    apply_stimulus(8'h00, 1'b1, "t1_b2");
    check_output("t1_busy_before_stop", 32'(busy), 1);
    i2c_stop();
    check_output("t1_busy_after_stop", 32'(busy), 0);
    check_output("t1_ack_slots", ack_count - a0, 3);
    check_output("t1_valid_count", valid_count - v0, 1);

    // Fast SCL from here on; extra byte in WAIT_STOP must be ignored.
    quarter = 10;
    v0 = valid_count;
    expect_write(7'h06, 9'h155);
    i2c_start();
    apply_stimulus(8'h34, 1'b1, "t2_addr");
    apply_stimulus(8'h0D, 1'b1, "t2_b1");
    apply_stimulus(8'h55, 1'b1, "t2_b2");
    apply_stimulus(8'hAA, 1'b0, "t2_extra");
    i2c_stop();
    check_output("t2_valid_count", valid_count - v0, 1);

    // Foreign address and read request.
    v0 = valid_count; a0 = ack_count; b0 = busy_cycles;
    i2c_start();
    apply_stimulus(8'h36, 1'b0, "t3_other_addr");
    i2c_stop();
    i2c_start();
    apply_stimulus(8'h35, 1'b0, "t3_read");
    i2c_stop();
    check_output("t3_ack_slots", ack_count - a0, 0);
    check_output("t3_busy_cycles", busy_cycles - b0, 0);
    check_output("t3_valid_count", valid_count - v0, 0);

    // STOP before byte 2 discards the write.
    v0 = valid_count;
    i2c_start();
    apply_stimulus(8'h34, 1'b1, "t4_addr");
    apply_stimulus(8'h1E, 1'b1, "t4_b1");
    i2c_stop();
    check_output("t4_valid_count", valid_count - v0, 0);
    check_output("t4_wr_addr_hold", 32'(wr_addr), 32'h06);
    check_output("t4_wr_data_hold", 32'(wr_data), 32'h155);
    check_output("t4_busy_after_stop", 32'(busy), 0);

    // Repeated START drops the first partial write.
    v0 = valid_count;
    expect_write(7'h06, 9'h0FF);
    i2c_start();
    apply_stimulus(8'h34, 1'b1, "t5_addr_a");
    apply_stimulus(8'h12, 1'b1, "t5_b1_a");
    i2c_rstart();
    apply_stimulus(8'h34, 1'b1, "t5_addr_b");
    apply_stimulus(8'h0C, 1'b1, "t5_b1_b");
    apply_stimulus(8'hFF, 1'b1, "t5_b2_b");
    i2c_stop();
    check_output("t5_valid_count", valid_count - v0, 1);

    // Reset pulsed while the target is driving the ACK_1 slot.
    v0 = valid_count;
    i2c_start();
    apply_stimulus(8'h34, 1'b1, "t6_addr");
    send_bits(8'h1E);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    check_output("t6_oe_in_ack1", 32'(sda_oe), 1);
    rst_n = 1'b0;
    #1;
    check_output("t6_oe_async_release", 32'(sda_oe), 0);
    check_output("t6_busy_in_reset", 32'(busy), 0);
    repeat (3) @(posedge clk_in);
    #1;
    check_output("t6_wr_addr_reset", 32'(wr_addr), 0);
    rst_n = 1'b1;
    wait_q(); wait_q();
    check_output("t6_no_valid_after_reset", valid_count - v0, 0);
    expect_write(7'h06, 9'h155);
    i2c_start();
    apply_stimulus(8'h34, 1'b1, "t6_addr2");
    apply_stimulus(8'h0D, 1'b1, "t6_b1");
    apply_stimulus(8'h55, 1'b1, "t6_b2");
    i2c_stop();
    check_output("t6_valid_count", valid_count - v0, 1);

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
